muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: WIDTH calculation cycles on operand
// magnitudes, then a single fix-up cycle that applies the signs and registers the results.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             sign,
   input  logic             annul,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t             state_r, state_nxt_s;
   logic               load_s, step_s, finish_s;
   logic [CNT_W-1:0]   cnt_r;
   logic               mode_r, neg_q_r, neg_rem_r, b_zero_r;
   logic [WIDTH-1:0]   p_hi_r, p_lo_r, mag_b_r, a_orig_r;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               done_r, dbz_r;

   logic [WIDTH:0]     mul_sum_s, div_shift_s;
   logic               div_ge_s;
   logic [WIDTH-1:0]   hi_nxt_s, lo_nxt_s, res_hi_s, res_lo_s;
   logic [2*WIDTH-1:0] prod_s;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
      return (s && v[WIDTH-1]) ? (ZERO - v) : v;
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath strobes; annul wins over every busy state
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      step_s      = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && !annul) begin
               load_s      = 1'b1;
               state_nxt_s = CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (annul) begin
               state_nxt_s = IDLE;
            end else begin
               step_s      = 1'b1;
               state_nxt_s = (cnt_r == CNT_LAST) ? FIX : CALC;
            end
         end
         FIX: begin
            finish_s    = !annul;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // One iteration step: p_hi holds partial product / remainder, p_lo holds multiplier / quotient
   always_comb begin
      mul_sum_s   = {1'b0, p_hi_r} + (p_lo_r[0] ? {1'b0, mag_b_r} : {1'b0, ZERO});
      div_shift_s = {p_hi_r, p_lo_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, mag_b_r});
      if (mode_r) begin
         hi_nxt_s = div_ge_s ? WIDTH'(div_shift_s - {1'b0, mag_b_r}) : div_shift_s[WIDTH-1:0];
         lo_nxt_s = {p_lo_r[WIDTH-2:0], div_ge_s};
      end else begin
         {hi_nxt_s, lo_nxt_s} = {mul_sum_s, p_lo_r[WIDTH-1:1]};
      end
   end

   // Sign correction of the raw magnitude result
   always_comb begin
      prod_s = {p_hi_r, p_lo_r};
      if (!mode_r) begin
         {res_hi_s, res_lo_s} = neg_q_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
      end else if (b_zero_r) begin
         res_lo_s = ONES;
         res_hi_s = a_orig_r;
      end else begin
         res_lo_s = neg_q_r   ? (ZERO - p_lo_r) : p_lo_r;
         res_hi_s = neg_rem_r ? (ZERO - p_hi_r) : p_hi_r;
      end
   end

   // Operand latch, iteration registers and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r     <= {CNT_W{1'b0}};
         mode_r    <= 1'b0;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         b_zero_r  <= 1'b0;
         p_hi_r    <= ZERO;
         p_lo_r    <= ZERO;
         mag_b_r   <= ZERO;
         a_orig_r  <= ZERO;
         hi_r      <= ZERO;
         lo_r      <= ZERO;
         done_r    <= 1'b0;
         dbz_r     <= 1'b0;
      end else begin
         done_r <= finish_s;
         if (load_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            mode_r    <= mode;
            neg_q_r   <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_r <= sign && a[WIDTH-1];
            b_zero_r  <= (b == ZERO);
            p_hi_r    <= ZERO;
            p_lo_r    <= magnitude(a, sign);
            mag_b_r   <= magnitude(b, sign);
            a_orig_r  <= a;
         end else if (step_s) begin
            cnt_r  <= cnt_r + CNT_W'(1);
            p_hi_r <= hi_nxt_s;
            p_lo_r <= lo_nxt_s;
         end
         if (finish_s) begin
            hi_r  <= res_hi_s;
            lo_r  <= res_lo_s;
            dbz_r <= mode_r && b_zero_r;
         end
      end
   end

   assign busy        = (state_r != IDLE);
   assign done        = done_r;
   assign hi          = hi_r;
   assign lo          = lo_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): hand-computed results, latency,
// annul, ignored starts and asynchronous reset behaviour.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0, mode = 1'b0, sign = 1'b0, annul = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [W-1:0] last_hi = '0, last_lo = '0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .sign(sign), .annul(annul),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Count every done pulse, sampled away from the active edge
   always @(negedge clk) begin
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic m, input logic s,
                         input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                         input logic e_dbz, input bit glitch);
      int cycles;
      @(negedge clk);
      start = 1'b1; mode = m; sign = s; a = va; b = vb;
      @(posedge clk); #1;
      start = 1'b0;
      exp_done++;
      check({tag, " busy"}, 64'(busy), 64'd1);
      cycles = 0;
      while (!done && cycles < 100) begin
         if (glitch && cycles == 5) begin
            start = 1'b1; a = 32'h0000_0001; b = 32'h0000_0001;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
      check({tag, " latency"}, 64'(cycles), 64'd33);
      check({tag, " lo"}, 64'(lo), 64'(e_lo));
      check({tag, " hi"}, 64'(hi), 64'(e_hi));
      check({tag, " dbz"}, 64'(div_by_zero), 64'(e_dbz));
      check({tag, " idle"}, 64'(busy), 64'd0);
      last_lo = e_lo;
      last_hi = e_hi;
   endtask

   initial begin
      #3;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      check("reset dbz", 64'(div_by_zero), 64'd0);
      @(negedge clk); rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("no done after reset", 64'(done_cnt), 64'd0);

      run_op("udiv 7/2",    1'b1, 1'b0, 32'd7,         32'd2,         32'h3,         32'h1,         1'b0, 1'b0);
      run_op("sdiv -7/2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("sdiv MIN/-1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, 1'b0);
      run_op("sdiv 7/-2",   1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1,         1'b0, 1'b0);
      run_op("smul -3*5",   1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("smul 7*-8",   1'b0, 1'b1, 32'd7,         32'hFFFF_FFF8, 32'hFFFF_FFC8, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("umul max^2",  1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("udiv by 0",   1'b1, 1'b0, 32'h1234,      32'h0,         32'hFFFF_FFFF, 32'h1234,      1'b1, 1'b0);
      run_op("udiv 100/7",  1'b1, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0);
      run_op("sdiv -5/0",   1'b1, 1'b1, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);
      run_op("busy start",  1'b0, 1'b0, 32'd1000,      32'd3000,      32'd3000000,   32'h0,         1'b0, 1'b1);

      // start together with annul in IDLE is ignored
      @(negedge clk);
      start = 1'b1; annul = 1'b1; mode = 1'b1; a = 32'd9; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; annul = 1'b0;
      check("start+annul idle", 64'(busy), 64'd0);

      // annul mid-calculation
      @(negedge clk);
      start = 1'b1; mode = 1'b1; sign = 1'b0; a = 32'd50; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0;
      check("annul busy", 64'(busy), 64'd0);
      check("annul lo", 64'(lo), 64'(last_lo));
      check("annul hi", 64'(hi), 64'(last_hi));
      repeat (40) @(posedge clk);
      #1 check("annul no done", 64'(done_cnt), 64'(exp_done));
      run_op("udiv 50/3",   1'b1, 1'b0, 32'd50,        32'd3,         32'd16,        32'd2,         1'b0, 1'b0);

      // asynchronous reset between edges, mid-CALC
      @(negedge clk);
      start = 1'b1; mode = 1'b0; sign = 1'b1; a = 32'hFFFF_FFFD; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst busy", 64'(busy), 64'd0);
      check("arst done", 64'(done), 64'd0);
      check("arst hi", 64'(hi), 64'd0);
      check("arst lo", 64'(lo), 64'd0);
      @(negedge clk); rst = 1'b1;
      repeat (40) @(posedge clk);
      #1 check("arst no done", 64'(done_cnt), 64'(exp_done));
      run_op("umul 2^32",   1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1,         1'b0, 1'b0);

      repeat (2) @(posedge clk);
      #1 check("done count", 64'(done_cnt), 64'(exp_done));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
